div32x16_seq: RTL

- Iterative restoring divider; the inverse of the filter and volume multipliers.
- Computes filter/envelope rate coefficients and normalisation factors from a 32-bit numerator and a 16-bit denominator.
- Shares one subtractor across NUM_W cycles instead of spending SB_MAC16 or DSP resources.
- Used from low-rate control paths (register writes, per-frame recompute) through a start/busy/done handshake.

---
 rtl/div32x16_seq_if.sv | 25 ++
 rtl/div32x16_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/div32x16_seq_if.sv
// rtl/div32x16_seq_if.sv - start/busy/done handshake bundle for the sequential divider
interface div32x16_seq_if #(
  parameter int NUM_W = 32,
  parameter int DEN_W = 16
);
  logic             iStart;
  logic [NUM_W-1:0] iNum;
  logic [DEN_W-1:0] iDen;
  logic [NUM_W-1:0] oQuot;
  logic [DEN_W-1:0] oRem;
  logic             oBusy;
  logic             oDone;
  logic             oDivZero;
  logic             oOverflow;

  modport master (
    output iStart, iNum, iDen,
    input  oQuot, oRem, oBusy, oDone, oDivZero, oOverflow
  );

  modport slave (
    input  iStart, iNum, iDen,
    output oQuot, oRem, oBusy, oDone, oDivZero, oOverflow
  );
endinterface

// File: rtl/div32x16_seq.sv
// rtl/div32x16_seq.sv - iterative restoring divider, one shared subtractor, signed or unsigned
module div32x16_seq #(
  parameter int NUM_W  = 32,
  parameter int DEN_W  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  div32x16_seq_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [NUM_W-1:0] num_sh;    // numerator magnitude shifting out, quotient bits shifting in
  logic [DEN_W-1:0] den_mag;
  logic [DEN_W-1:0] prem;      // partial remainder, always < den_mag between steps
  logic [DEN_W-1:0] num_lo;    // raw low numerator bits, returned as remainder on divide-by-zero
  logic             num_neg, den_neg, den_zero;

  logic [NUM_W-1:0] quot_r;
  logic [DEN_W-1:0] rem_r;
  logic             done_r, dz_r, ov_r;

  logic             start_ok;
  logic             num_in_neg, den_in_neg;
  logic [NUM_W-1:0] num_in_mag;
  logic [DEN_W-1:0] den_in_mag;
  logic [DEN_W:0]   shifted, trial;
  logic             q_bit;
  logic [DEN_W-1:0] prem_nxt;
  logic             q_neg, ovf;
  logic [NUM_W-1:0] quot_fix, quot_sat;
  logic [DEN_W-1:0] rem_fix;

  assign start_ok   = (state == S_IDLE) && bus.iStart;
  assign num_in_neg = SIGNED && bus.iNum[NUM_W-1];
  assign den_in_neg = SIGNED && bus.iDen[DEN_W-1];
  assign num_in_mag = num_in_neg ? -bus.iNum : bus.iNum;
  assign den_in_mag = den_in_neg ? -bus.iDen : bus.iDen;

  // One restoring step: bring down the next numerator bit, keep the difference if it did not go negative
  assign shifted  = {prem, num_sh[NUM_W-1]};
  assign trial    = shifted - {1'b0, den_mag};
  assign q_bit    = ~trial[DEN_W];
  assign prem_nxt = q_bit ? trial[DEN_W-1:0] : shifted[DEN_W-1:0];

  // Sign fix-up: truncation toward zero, remainder follows the numerator
  assign q_neg    = num_neg ^ den_neg;
  assign quot_fix = q_neg ? -num_sh : num_sh;
  assign rem_fix  = num_neg ? -prem : prem;
  // Only -2^(NUM_W-1) / -1 produces a positive magnitude with the top bit set
  assign ovf      = SIGNED && !q_neg && num_sh[NUM_W-1];
  assign quot_sat = !SIGNED ? {NUM_W{1'b1}} :
                    (num_neg ? {1'b1, {(NUM_W-1){1'b0}}} : {1'b0, {(NUM_W-1){1'b1}}});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a zero denominator makes a single dummy pass through DIV
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.iStart) state_nxt = S_DIV;
      S_DIV:   if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      num_sh   <= '0;
      den_mag  <= '0;
      prem     <= '0;
      num_lo   <= '0;
      num_neg  <= 1'b0;
      den_neg  <= 1'b0;
      den_zero <= 1'b0;
      quot_r   <= '0;
      rem_r    <= '0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
      ov_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start_ok) begin
        num_sh   <= num_in_mag;
        den_mag  <= den_in_mag;
        prem     <= '0;
        num_lo   <= bus.iNum[DEN_W-1:0];
        num_neg  <= num_in_neg;
        den_neg  <= den_in_neg;
        den_zero <= (bus.iDen == '0);
        cnt      <= (bus.iDen == '0) ? '0 : CNT_W'(NUM_W-1);
      end else if (state == S_DIV) begin
        num_sh <= {num_sh[NUM_W-2:0], q_bit};
        prem   <= prem_nxt;
        cnt    <= cnt - 1'b1;
      end else if (state == S_FIX) begin
        done_r <= 1'b1;
        if (den_zero) begin
          quot_r <= quot_sat;
          rem_r  <= num_lo;
          dz_r   <= 1'b1;
          ov_r   <= 1'b0;
        end else if (ovf) begin
          quot_r <= {1'b0, {(NUM_W-1){1'b1}}};
          rem_r  <= '0;
          dz_r   <= 1'b0;
          ov_r   <= 1'b1;
        end else begin
          quot_r <= quot_fix;
          rem_r  <= rem_fix;
          dz_r   <= 1'b0;
          ov_r   <= 1'b0;
        end
      end
    end
  end

  assign bus.oQuot     = quot_r;
  assign bus.oRem      = rem_r;
  assign bus.oBusy     = (state != S_IDLE);
  assign bus.oDone     = done_r;
  assign bus.oDivZero  = dz_r;
  assign bus.oOverflow = ov_r;
endmodule
